// File: rtl/sram_arb_pkg.sv
// Shared types and default widths for the SRAM port arbiter.
//   sram_arb_state_t : arbiter FSM state (read-priority / forced-write)
//   SRAM_ADDR_W      : default SRAM address width
//   SRAM_DATA_W      : default SRAM data width
package sram_arb_pkg;

    localparam int unsigned SRAM_ADDR_W = 18;
    localparam int unsigned SRAM_DATA_W = 16;

    typedef enum logic [0:0] {
        S_RD_PRI   = 1'b0,
        S_WR_FORCE = 1'b1
    } sram_arb_state_t;

endpackage

// File: rtl/sram_rd_tracker.sv
// Valid shift pipe that follows issued reads to their data return.
//   Clock, Resetn : clock, synchronous active-low reset
//   issue_i       : a read is granted this cycle
//   valid_o       : tail of the pipe, read data valid this cycle
module sram_rd_tracker #(
    parameter int unsigned DEPTH = 3
) (
    input  logic Clock,
    input  logic Resetn,
    input  logic issue_i,
    output logic valid_o
);

    logic [DEPTH-1:0] pipe_q;

    // One bit per in-flight read; shifting preserves issue order.
    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            pipe_q <= '0;
        end else begin
            pipe_q <= (pipe_q << 1) | DEPTH'(issue_i);
        end
    end

    assign valid_o = pipe_q[DEPTH-1];

endmodule

// File: rtl/sram_port_arbiter.sv
// Arbiter and sequencer for the single external SRAM port.
// Reads (VGA fetch) have priority; a wait counter forces the write port
// (UART loader) through after MAX_WAIT denied cycles.
// Optional performance counters: define SRAM_ARB_PERF_EN.
// Ports:
//   Clock, Resetn                 : clock, synchronous active-low reset
//   rd_req/rd_addr -> rd_gnt      : read request, combinational grant
//   rd_data, rd_valid             : returned read data and its strobe
//   wr_req/wr_addr/wr_data -> wr_gnt : write request, combinational grant
//   starving                      : arbiter is forcing a write through
//   SRAM_address/_write_data/_we_n: registered controller command
//   SRAM_read_data                : data from the controller
//   rd_count, wr_count, force_count : performance counters (0 if disabled)
module sram_port_arbiter
    import sram_arb_pkg::*;
#(
    parameter int unsigned ADDR_W     = SRAM_ADDR_W,
    parameter int unsigned DATA_W     = SRAM_DATA_W,
    parameter int unsigned RD_LATENCY = 2,
    parameter int unsigned MAX_WAIT   = 8
) (
    input  logic              Clock,
    input  logic              Resetn,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_gnt,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_gnt,
    output logic              starving,
    output logic [ADDR_W-1:0] SRAM_address,
    output logic [DATA_W-1:0] SRAM_write_data,
    output logic              SRAM_we_n,
    input  logic [DATA_W-1:0] SRAM_read_data,
    output logic [31:0]       rd_count,
    output logic [31:0]       wr_count,
    output logic [15:0]       force_count
);

    localparam logic [7:0] WAIT_MAX = 8'(MAX_WAIT);

    sram_arb_state_t   state_q;
    logic [7:0]        wait_q, wait_d;
    logic              force_enter;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              we_n_q;

    // Grants, wait counter next value and forced-write entry condition.
    always_comb begin
        rd_gnt      = 1'b0;
        wr_gnt      = 1'b0;
        wait_d      = wait_q;
        force_enter = 1'b0;
        case (state_q)
            S_RD_PRI: begin
                rd_gnt = rd_req;
                wr_gnt = wr_req & ~rd_req;
            end
            S_WR_FORCE: begin
                wr_gnt = wr_req;
                rd_gnt = rd_req & ~wr_req;
            end
            default: ;
        endcase
        if (wr_gnt || !wr_req) begin
            wait_d = '0;
        end else if (wait_q < WAIT_MAX) begin
            wait_d = wait_q + 8'd1;
        end
        // Entering on the edge where the counter reaches MAX_WAIT gives the
        // write its grant in the very next cycle.
        force_enter = (state_q == S_RD_PRI) && (wait_d == WAIT_MAX);
    end

    // Arbiter FSM and wait counter.
    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            state_q <= S_RD_PRI;
            wait_q  <= '0;
        end else begin
            wait_q <= wait_d;
            case (state_q)
                S_RD_PRI:   if (force_enter) state_q <= S_WR_FORCE;
                S_WR_FORCE: if (wr_gnt || !wr_req) state_q <= S_RD_PRI;
                default:    state_q <= S_RD_PRI;
            endcase
        end
    end

    // Issue register: one command per grant, idle cycles deassert we_n only.
    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            addr_q  <= '0;
            wdata_q <= '0;
            we_n_q  <= 1'b1;
        end else if (wr_gnt) begin
            addr_q  <= wr_addr;
            wdata_q <= wr_data;
            we_n_q  <= 1'b0;
        end else if (rd_gnt) begin
            addr_q  <= rd_addr;
            we_n_q  <= 1'b1;
        end else begin
            we_n_q  <= 1'b1;
        end
    end

    assign SRAM_address    = addr_q;
    assign SRAM_write_data = wdata_q;
    assign SRAM_we_n       = we_n_q;
    assign starving        = (state_q == S_WR_FORCE);
    assign rd_data         = SRAM_read_data;

    // Address reaches the controller one cycle after the grant.
    sram_rd_tracker #(
        .DEPTH (RD_LATENCY + 1)
    ) u_rd_tracker (
        .Clock   (Clock),
        .Resetn  (Resetn),
        .issue_i (rd_gnt),
        .valid_o (rd_valid)
    );

`ifdef SRAM_ARB_PERF_EN
    logic [31:0] rd_cnt_q, wr_cnt_q;
    logic [15:0] force_cnt_q;

    // Grant counters wrap; forced-entry counter saturates.
    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            rd_cnt_q    <= '0;
            wr_cnt_q    <= '0;
            force_cnt_q <= '0;
        end else begin
            if (rd_gnt) rd_cnt_q <= rd_cnt_q + 32'd1;
            if (wr_gnt) wr_cnt_q <= wr_cnt_q + 32'd1;
            if (force_enter && (force_cnt_q != 16'hFFFF)) force_cnt_q <= force_cnt_q + 16'd1;
        end
    end

    assign rd_count    = rd_cnt_q;
    assign wr_count    = wr_cnt_q;
    assign force_count = force_cnt_q;
`else
    assign rd_count    = '0;
    assign wr_count    = '0;
    assign force_count = '0;
`endif

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter with a small SRAM controller model
// (two-cycle read latency after the address is presented).
module tb_sram_port_arbiter;

    logic        Clock;
    logic        Resetn;
    logic        rd_req;
    logic [17:0] rd_addr;
    logic        rd_gnt;
    logic [15:0] rd_data;
    logic        rd_valid;
    logic        wr_req;
    logic [17:0] wr_addr;
    logic [15:0] wr_data;
    logic        wr_gnt;
    logic        starving;
    logic [17:0] SRAM_address;
    logic [15:0] SRAM_write_data;
    logic        SRAM_we_n;
    logic [15:0] SRAM_read_data;
    logic [31:0] rd_count;
    logic [31:0] wr_count;
    logic [15:0] force_count;

    int n_tests = 0;
    int n_fail  = 0;
    int rd_gnt_seen = 0;

    sram_port_arbiter dut (
        .Clock           (Clock),
        .Resetn          (Resetn),
        .rd_req          (rd_req),
        .rd_addr         (rd_addr),
        .rd_gnt          (rd_gnt),
        .rd_data         (rd_data),
        .rd_valid        (rd_valid),
        .wr_req          (wr_req),
        .wr_addr         (wr_addr),
        .wr_data         (wr_data),
        .wr_gnt          (wr_gnt),
        .starving        (starving),
        .SRAM_address    (SRAM_address),
        .SRAM_write_data (SRAM_write_data),
        .SRAM_we_n       (SRAM_we_n),
        .SRAM_read_data  (SRAM_read_data),
        .rd_count        (rd_count),
        .wr_count        (wr_count),
        .force_count     (force_count)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // SRAM controller model: write on we_n low, read data two cycles after address.
    logic [15:0] mem [0:(1<<18)-1];
    logic [15:0] rd_d1, rd_d2;
    always @(posedge Clock) begin
        if (!SRAM_we_n) mem[SRAM_address] <= SRAM_write_data;
        rd_d1 <= mem[SRAM_address];
        rd_d2 <= rd_d1;
    end
    assign SRAM_read_data = rd_d2;

    // Observed read grants since the last reset.
    always @(negedge Clock) begin
        if (!Resetn) rd_gnt_seen <= 0;
        else if (rd_gnt) rd_gnt_seen <= rd_gnt_seen + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        Resetn = 1'b0; rd_req = 1'b0; rd_addr = '0;
        wr_req = 1'b0; wr_addr = '0; wr_data = '0;
        mem[18'h00010] = 16'h1234;
        for (int i = 0; i < 4; i++) mem[18'h00100 + i] = 16'hC000 + 16'(i);
        repeat (3) tick();

        // Reset state
        @(negedge Clock);
        check_eq("rst_we_n", 32'(SRAM_we_n), 32'd1);
        check_eq("rst_addr", 32'(SRAM_address), 32'd0);
        check_eq("rst_valid", 32'(rd_valid), 32'd0);
        check_eq("rst_starving", 32'(starving), 32'd0);
        check_eq("rst_rd_count", rd_count, 32'd0);
        tick(); Resetn = 1'b1;
        tick();

        // 1: single read
        rd_req = 1'b1; rd_addr = 18'h00010;
        @(negedge Clock);
        check_eq("t1_rd_gnt", 32'(rd_gnt), 32'd1);
        check_eq("t1_wr_gnt", 32'(wr_gnt), 32'd0);
        tick(); rd_req = 1'b0; rd_addr = 18'h3AAAA;
        @(negedge Clock);
        check_eq("t1_addr", 32'(SRAM_address), 32'h10);
        check_eq("t1_we_n", 32'(SRAM_we_n), 32'd1);
        check_eq("t1_valid_t1", 32'(rd_valid), 32'd0);
        tick(); @(negedge Clock);
        check_eq("t1_valid_t2", 32'(rd_valid), 32'd0);
        tick(); @(negedge Clock);
        check_eq("t1_valid_t3", 32'(rd_valid), 32'd1);
        check_eq("t1_data", 32'(rd_data), 32'h1234);
        tick(); @(negedge Clock);
        check_eq("t1_valid_t4", 32'(rd_valid), 32'd0);
        tick();

        // 2: single write, then read it back
        wr_req = 1'b1; wr_addr = 18'h3FFFF; wr_data = 16'hA5C3;
        @(negedge Clock);
        check_eq("t2_wr_gnt", 32'(wr_gnt), 32'd1);
        check_eq("t2_rd_gnt", 32'(rd_gnt), 32'd0);
        tick(); wr_req = 1'b0; wr_addr = 18'h00001; wr_data = 16'h0000;
        @(negedge Clock);
        check_eq("t2_we_n", 32'(SRAM_we_n), 32'd0);
        check_eq("t2_addr", 32'(SRAM_address), 32'h3FFFF);
        check_eq("t2_wdata", 32'(SRAM_write_data), 32'hA5C3);
        tick(); @(negedge Clock);
        check_eq("t2_we_n_after", 32'(SRAM_we_n), 32'd1);
        rd_req = 1'b0;
        tick();
        rd_req = 1'b1; rd_addr = 18'h3FFFF;
        tick(); rd_req = 1'b0;
        tick(); tick();
        @(negedge Clock);
        check_eq("t2_rb_valid", 32'(rd_valid), 32'd1);
        check_eq("t2_rb_data", 32'(rd_data), 32'hA5C3);
        tick(); tick();

        // 4: back-to-back burst, data returns in order without gaps
        for (int k = 0; k < 9; k++) begin
            rd_req  = (k < 4);
            rd_addr = 18'h00100 + 18'(k);
            @(negedge Clock);
            check_eq($sformatf("t4_valid_%0d", k), 32'(rd_valid), 32'((k >= 3) && (k <= 6)));
            if (k >= 3 && k <= 6)
                check_eq($sformatf("t4_data_%0d", k), 32'(rd_data), 32'h0000C000 + 32'(k - 3));
            tick();
        end

        // 5: reset the cycle after a read grant drops the in-flight read
        rd_req = 1'b1; rd_addr = 18'h00010;
        tick(); rd_req = 1'b0; Resetn = 1'b0;
        tick(); Resetn = 1'b1;
        @(negedge Clock);
        check_eq("t5_we_n", 32'(SRAM_we_n), 32'd1);
        check_eq("t5_starving", 32'(starving), 32'd0);
        check_eq("t5_valid_t2", 32'(rd_valid), 32'd0);
        check_eq("t5_rd_count", rd_count, 32'd0);
        check_eq("t5_wr_count", wr_count, 32'd0);
        check_eq("t5_force_count", 32'(force_count), 32'd0);
        tick(); @(negedge Clock);
        check_eq("t5_valid_t3", 32'(rd_valid), 32'd0);
        tick(); @(negedge Clock);
        check_eq("t5_valid_t4", 32'(rd_valid), 32'd0);
        tick();

        // 3: starvation under continuous reads
        wr_addr = 18'h00200; wr_data = 16'hBEEF;
        for (int k = 0; k < 10; k++) begin
            rd_req = 1'b1; rd_addr = 18'h00300 + 18'(k);
            wr_req = (k <= 8);
            @(negedge Clock);
            check_eq($sformatf("t3_rd_gnt_%0d", k), 32'(rd_gnt), 32'(k != 8));
            check_eq($sformatf("t3_wr_gnt_%0d", k), 32'(wr_gnt), 32'(k == 8));
            check_eq($sformatf("t3_starving_%0d", k), 32'(starving), 32'(k == 8));
            if (k == 9) begin
                check_eq("t3_we_n", 32'(SRAM_we_n), 32'd0);
                check_eq("t3_addr", 32'(SRAM_address), 32'h200);
                check_eq("t3_wdata", 32'(SRAM_write_data), 32'hBEEF);
            end
            tick();
        end

        // Extra forced write
        wr_addr = 18'h00201; wr_data = 16'h1357;
        for (int j = 0; j < 9; j++) begin
            rd_req = 1'b1; rd_addr = 18'h00310 + 18'(j);
            wr_req = 1'b1;
            @(negedge Clock);
            check_eq($sformatf("t6_wr_gnt_%0d", j), 32'(wr_gnt), 32'(j == 8));
            tick();
        end
        rd_req = 1'b0; wr_req = 1'b0;
        @(negedge Clock);
        check_eq("t6_we_n", 32'(SRAM_we_n), 32'd0);
        check_eq("t6_addr", 32'(SRAM_address), 32'h201);
        tick(); @(negedge Clock);

        // 6: performance counters
`ifdef SRAM_ARB_PERF_EN
        check_eq("t6_force_count", 32'(force_count), 32'd2);
        check_eq("t6_wr_count", wr_count, 32'd2);
        check_eq("t6_rd_count", rd_count, 32'(rd_gnt_seen));
`else
        check_eq("t6_force_count", 32'(force_count), 32'd0);
        check_eq("t6_wr_count", wr_count, 32'd0);
        check_eq("t6_rd_count", rd_count, 32'd0);
`endif
        check_eq("t6_rd_gnt_seen", 32'(rd_gnt_seen), 32'd17);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sram_port_arbiter.md
# sram_port_arbiter

Two-requester arbiter and sequencer for the single external SRAM port. It sits between the SRAM controller and its two clients: the VGA pixel fetch path (read port) and the UART image loader (write port). Reads have priority so the display never misses a fetch deadline. A starvation guard still lets the loader through so frame uploads make progress during active video.

## Interface
- `ADDR_W`, 18: SRAM address width.
- `DATA_W`, 16: SRAM data width.
- `RD_LATENCY`, 2: cycles from controller address sample to valid `SRAM_read_data`.
- `MAX_WAIT`, 8: denied write cycles before the write port is forced through (range 1..255).
- `Clock` in 1: 50 MHz system clock. Single clock domain.
- `Resetn` in 1: synchronous, active-low reset.
- `rd_req` in 1: read request. Held with `rd_addr` until `rd_gnt`.
- `rd_addr` in ADDR_W: read address.
- `rd_gnt` out 1: combinational grant. The read is issued this cycle.
- `rd_data` out DATA_W: returned read data.
- `rd_valid` out 1: `rd_data` is valid this cycle.
- `wr_req` in 1: write request. Held with `wr_addr`/`wr_data` until `wr_gnt`.
- `wr_addr` in ADDR_W; `wr_data` in DATA_W.
- `wr_gnt` out 1: combinational grant. The write is issued this cycle.
- `starving` out 1: high while the arbiter is in `S_WR_FORCE`.
- `SRAM_address` out ADDR_W; `SRAM_write_data` out DATA_W; `SRAM_we_n` out 1: registered controller command.
- `SRAM_read_data` in DATA_W: data from the controller.
- `rd_count`, `wr_count` out 32; `force_count` out 16: performance counters (see Configuration).

## Operation
- FSM states:
  - `S_RD_PRI` (reset state).
  - `S_WR_FORCE`.
- Grant in `S_RD_PRI`:
  - `rd_gnt = rd_req`.
  - `wr_gnt = wr_req & ~rd_req`.
- Grant in `S_WR_FORCE`:
  - `wr_gnt = wr_req`.
  - `rd_gnt = rd_req & ~wr_req`.
- `rd_gnt` and `wr_gnt` are never high together.
- Wait counter (8 bit):
  - Increments in each cycle where `wr_req & ~wr_gnt`, saturating at `MAX_WAIT`.
  - Clears on `wr_gnt` or on `~wr_req`.
- State transitions:
  - `S_RD_PRI` → `S_WR_FORCE` when the counter equals `MAX_WAIT` at a clock edge.
  - `S_WR_FORCE` → `S_RD_PRI` on the edge after `wr_gnt`, or when `wr_req` drops (withdrawal is permitted only in this state).
- Issue register, updated on every edge:
  - On a grant: `SRAM_address` ← granted address; `SRAM_we_n` ← `~wr_gnt`; `SRAM_write_data` ← `wr_data` when writing.
  - With no grant: `SRAM_we_n` ← 1 and `SRAM_address` holds its value.
- Read tracking:
  - A shift register of depth `RD_LATENCY+1` tracks in-flight reads.
  - `rd_valid` is its tail; `rd_data = SRAM_read_data` unregistered.
  - Reads return strictly in issue order. One read per cycle is sustained.
- Reset values:
  - All outputs 0 except `SRAM_we_n` = 1.
  - State `S_RD_PRI`; wait counter 0; valid pipe cleared.
  - Reset asserted mid-read drops every in-flight `rd_valid`.

## Timing
- `rd_gnt` in cycle t:
  - `SRAM_address` is valid in t+1.
  - `rd_valid`/`rd_data` are valid in t+1+`RD_LATENCY`, i.e. t+3 at the default.
- `wr_gnt` in cycle t: `SRAM_we_n` is low for exactly cycle t+1 (per grant), with address and data stable.
- A write after a read, or a read after a write, needs no turnaround cycle. The controller absorbs bus direction changes.
- Worst-case write wait under continuous reads: `MAX_WAIT`+1 cycles from first request to `wr_gnt`.
- Worst-case read deferral: 1 cycle per forced write.

## Configuration
- `SRAM_ARB_PERF_EN` defined:
  - `rd_count` and `wr_count` increment on each grant and wrap at 2^32.
  - `force_count` increments on each entry to `S_WR_FORCE` and saturates at 0xFFFF.
  - All three clear on reset.
- Not defined: the counter ports remain present and are tied to 0. No counter registers are inferred.

## Structure
- Shared package `sram_arb_pkg`:
  - `sram_arb_state_t` enum (`S_RD_PRI`, `S_WR_FORCE`).
  - Default width constants (`SRAM_ADDR_W` = 18, `SRAM_DATA_W` = 16).
- One sub-module, `sram_rd_tracker`: the parameterised valid shift pipe. Everything else stays in the top module.

## Test plan
1. Read only: `rd_req` for one cycle with `rd_addr` = 0x00010, emulator word 0x1234.
   - `rd_gnt` in the same cycle; `SRAM_address` = 0x00010 next cycle; `SRAM_we_n` = 1.
   - `rd_valid` = 1 with `rd_data` = 0x1234 three cycles after the grant.
2. Write only: `wr_req` with 0x3FFFF/0xA5C3.
   - `wr_gnt` in the same cycle; `SRAM_we_n` low for one cycle with 0x3FFFF/0xA5C3.
   - The emulator word reads back 0xA5C3.
3. Starvation: continuous `rd_req` plus `wr_req` from cycle 0.
   - `starving` rises after 8 denied cycles; `wr_gnt` in cycle 8; `rd_gnt` low only in cycle 8.
   - Returns to `S_RD_PRI` next cycle.
4. Burst order: reads of 0x00100–0x00103 back-to-back.
   - Four consecutive `rd_valid` cycles, data in address order, no gaps.
5. Reset mid-operation: `Resetn` low the cycle after a `rd_gnt`.
   - No `rd_valid` appears; `SRAM_we_n` = 1; `starving` = 0; counters cleared.
6. Performance counters, with `SRAM_ARB_PERF_EN` defined, after scenario 3 plus one extra forced write.
   - `force_count` = 2; `wr_count` = 2; `rd_count` equals the observed number of `rd_gnt` pulses.
   - Undefined build: all three read 0.
